// File: rtl/char_horizontal_projection.sv
// Row projection of a binary plate image: finds the first populated row run that is tall enough
// and publishes its top/bottom rows at frame end. Optional macro CHAR_HPROJ_MARGIN_EN widens the band by MARGIN rows.
module char_horizontal_projection #(
    parameter logic [9:0] IMG_HDISP  = 10'd640,
    parameter logic [9:0] IMG_VDISP  = 10'd480,
    parameter logic [9:0] ROW_THRESH = 10'd3,
    parameter logic [9:0] MIN_HEIGHT = 10'd8,
    parameter logic [9:0] MARGIN     = 10'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_Bit,
    input  logic [9:0] horizon_start,
    input  logic [9:0] horizon_end,
    output logic [9:0] char_line_up,
    output logic [9:0] char_line_down,
    output logic       char_valid,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit
);

    typedef enum logic [1:0] {IDLE, SEEK, BAND, LOCKED} state_t;

    logic vsync_d1, vsync_d2, href_d1, href_d2;
    logic clken_d1, clken_d2, bit_d1, bit_d2;
    logic [9:0] x_cnt, y_cnt, row_sum;

    state_t state, row_state;
    logic [9:0] top, bot, run;
    logic [9:0] row_top, row_bot, row_run;
    logic [9:0] pub_up, pub_down;

    logic href_fall, vsync_rise, vsync_fall, pixel_hit, row_populated;

    assign href_fall     = href_d1 & ~per_frame_href;
    assign vsync_rise    = vsync_d1 & ~vsync_d2;
    assign vsync_fall    = vsync_d2 & ~vsync_d1;
    assign pixel_hit     = per_frame_clken & per_img_Bit &
                           (x_cnt > horizon_start) & (x_cnt < horizon_end);
    assign row_populated = (row_sum >= ROW_THRESH);

    assign post_frame_vsync = vsync_d2;
    assign post_frame_href  = href_d2;
    assign post_frame_clken = clken_d2;
    assign post_img_Bit     = bit_d2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d1 <= 1'b0;
            vsync_d2 <= 1'b0;
            href_d1  <= 1'b0;
            href_d2  <= 1'b0;
            clken_d1 <= 1'b0;
            clken_d2 <= 1'b0;
            bit_d1   <= 1'b0;
            bit_d2   <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            row_sum  <= '0;
        end else begin
            vsync_d1 <= per_frame_vsync;
            vsync_d2 <= vsync_d1;
            href_d1  <= per_frame_href;
            href_d2  <= href_d1;
            clken_d1 <= per_frame_clken;
            clken_d2 <= clken_d1;
            bit_d1   <= per_img_Bit;
            bit_d2   <= bit_d1;

            // Counters saturate at the frame size so malformed syncs cannot wrap them.
            if (href_fall)
                x_cnt <= '0;
            else if (per_frame_clken && x_cnt < IMG_HDISP)
                x_cnt <= x_cnt + 10'd1;

            if (href_fall)
                row_sum <= '0;
            else if (pixel_hit)
                row_sum <= row_sum + 10'd1;

            if (vsync_fall)
                y_cnt <= '0;
            else if (href_fall && y_cnt < IMG_VDISP)
                y_cnt <= y_cnt + 10'd1;
        end
    end

    // Row-end decision, kept separate so a coinciding frame-end publish sees the updated band.
    always_comb begin
        row_state = state;
        row_top   = top;
        row_bot   = bot;
        row_run   = run;
        if (href_fall) begin
            case (state)
                SEEK: begin
                    if (row_populated) begin
                        row_top   = y_cnt;
                        row_bot   = y_cnt;
                        row_run   = 10'd1;
                        row_state = BAND;
                    end
                end
                BAND: begin
                    if (row_populated) begin
                        row_run = run + 10'd1;
                        row_bot = y_cnt;
                    end else if (run >= MIN_HEIGHT) begin
                        row_state = LOCKED;
                    end else begin
                        row_run   = '0;
                        row_state = SEEK;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHAR_HPROJ_MARGIN_EN
    logic [10:0] bot_ext;
    assign bot_ext  = {1'b0, row_bot} + {1'b0, MARGIN};
    assign pub_up   = (row_top > MARGIN) ? row_top - MARGIN : '0;
    assign pub_down = (bot_ext > {1'b0, IMG_VDISP - 10'd1}) ? IMG_VDISP - 10'd1 : bot_ext[9:0];
`else
    assign pub_up   = row_top;
    assign pub_down = row_bot;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            top            <= '0;
            bot            <= '0;
            run            <= '0;
            char_line_up   <= '0;
            char_line_down <= '0;
            char_valid     <= 1'b0;
        end else begin
            state <= row_state;
            top   <= row_top;
            bot   <= row_bot;
            run   <= row_run;
            if (vsync_rise) begin
                state <= IDLE;
                case (row_state)
                    LOCKED: begin
                        char_line_up   <= pub_up;
                        char_line_down <= pub_down;
                        char_valid     <= 1'b1;
                    end
                    BAND: begin
                        if (row_run >= MIN_HEIGHT) begin
                            char_line_up   <= pub_up;
                            char_line_down <= pub_down;
                            char_valid     <= 1'b1;
                        end else begin
                            char_line_up   <= '0;
                            char_line_down <= '0;
                            char_valid     <= 1'b0;
                        end
                    end
                    SEEK: begin
                        char_line_up   <= '0;
                        char_line_down <= '0;
                        char_valid     <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (vsync_fall && state == IDLE) begin
                state <= SEEK;
            end
        end
    end

endmodule

// File: tb/tb_char_horizontal_projection.sv
// Self-checking bench for char_horizontal_projection on a 64x48 frame with a behavioural row-run model.
module tb_char_horizontal_projection;

    localparam int W = 64;
    localparam int H = 48;
`ifdef CHAR_HPROJ_MARGIN_EN
    localparam int MG = 2;
`else
    localparam int MG = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b1, hr = 1'b0, ce = 1'b0, pb = 1'b0;
    logic [9:0] hs = 10'd10, he = 10'd50;
    logic [9:0] char_line_up, char_line_down;
    logic char_valid, post_vs, post_hr, post_ce, post_pb;

    char_horizontal_projection #(
        .IMG_HDISP(10'd64), .IMG_VDISP(10'd48), .ROW_THRESH(10'd3),
        .MIN_HEIGHT(10'd8), .MARGIN(10'd2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_Bit(pb),
        .horizon_start(hs), .horizon_end(he),
        .char_line_up(char_line_up), .char_line_down(char_line_down), .char_valid(char_valid),
        .post_frame_vsync(post_vs), .post_frame_href(post_hr),
        .post_frame_clken(post_ce), .post_img_Bit(post_pb)
    );

    always #5 clk = ~clk;

    bit fg [0:H-1][0:W-1];
    int tests = 0;
    int fails = 0;

    logic [9:0] pend_up = '0, pend_down = '0;
    logic       pend_valid = 1'b0;
    logic [9:0] exp_up = '0, exp_down = '0;
    logic       exp_valid = 1'b0;
    bit armed = 0, v1 = 0, v2 = 0, started = 0;
    logic [3:0] h_last = '0, h_prev = '0;

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // First populated run (>= 3 in-window pixels per row) lasting at least 8 rows.
    function automatic void model_frame(input int hs_i, input int he_i,
                                        output logic [9:0] up, output logic [9:0] down,
                                        output logic valid);
        int run, start, t, b, cnt;
        bit found;
        run = 0; start = 0; t = 0; b = 0; found = 0;
        for (int r = 0; r < H; r++) begin
            cnt = 0;
            for (int c = 0; c < W; c++)
                if (fg[r][c] && c > hs_i && c < he_i) cnt++;
            if (!found) begin
                if (cnt >= 3) begin
                    if (run == 0) start = r;
                    run++;
                end else begin
                    if (run >= 8) begin found = 1; t = start; b = r - 1; end
                    run = 0;
                end
            end
        end
        if (!found && run >= 8) begin found = 1; t = start; b = H - 1; end
        valid = found;
        up = '0; down = '0;
        if (found) begin
            up   = 10'((t > MG) ? t - MG : 0);
            down = 10'((b + MG > H - 1) ? H - 1 : b + MG);
        end
    endfunction

    task automatic clear_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) fg[r][c] = 0;
    endtask

    task automatic set_rows(input int r0, input int r1, input int c0, input int c1);
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++) fg[r][c] = 1;
    endtask

    // Reference: track sampled vsync; a frame result lands one edge after vsync is first seen high.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_up = '0; exp_down = '0; exp_valid = 1'b0;
            armed = 0; v1 = 0; v2 = 0; h_last = '0; h_prev = '0;
            started = 1;
        end else begin
            if (v1 && !v2) begin
                if (armed) begin
                    exp_up = pend_up; exp_down = pend_down; exp_valid = pend_valid;
                end
                armed = 0;
            end
            if (v1 && !vs) armed = 1;
            v2 = v1;
            v1 = vs;
            h_prev = h_last;
            h_last = {vs, hr, ce, pb};
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("up", char_line_up, exp_up);
            checkOutput("down", char_line_down, exp_down);
            checkOutput("valid", {9'd0, char_valid}, {9'd0, exp_valid});
            checkOutput("post", {6'd0, post_vs, post_hr, post_ce, post_pb}, {6'd0, h_prev});
        end
    end

    task automatic applyStimulus(input int hs_i, input int he_i, input int reset_row);
        int c;
        hs = 10'(hs_i);
        he = 10'(he_i);
        model_frame(hs_i, he_i, pend_up, pend_down, pend_valid);
        vs = 1'b0;
        repeat (4) @(negedge clk);
        for (int r = 0; r < H; r++) begin
            if (r == reset_row) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            hr = 1'b1;
            c = 0;
            while (c < W) begin
                ce = ($urandom_range(0, 7) != 0);
                if (ce) begin
                    pb = fg[r][c];
                    c++;
                end else begin
                    pb = ($urandom_range(0, 1) == 1);
                end
                @(negedge clk);
            end
            hr = 1'b0;
            ce = 1'b0;
            repeat (3) begin
                pb = ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
        end
        pb = 1'b0;
        repeat (2) @(negedge clk);
        vs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_band(input string name, input int up, input int down, input bit valid);
        checkOutput({name, "_up"}, char_line_up, 10'(up));
        checkOutput({name, "_down"}, char_line_down, 10'(down));
        checkOutput({name, "_valid"}, {9'd0, char_valid}, {9'd0, valid});
    endtask

    initial begin
        logic [9:0] mu, md;
        logic mv;
        int start, len;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        clear_frame();
        set_rows(12, 27, 20, 25);
        model_frame(10, 50, mu, md, mv);
        checkOutput("model_p1_up", mu, 10'(12 - MG));
        checkOutput("model_p1_down", md, 10'(27 + MG));
        applyStimulus(10, 50, -1);
        check_band("basic", 12 - MG, 27 + MG, 1);

        clear_frame();
        set_rows(5, 7, 20, 25);
        set_rows(20, 31, 20, 25);
        model_frame(10, 50, mu, md, mv);
        checkOutput("model_p2_up", mu, 10'(20 - MG));
        applyStimulus(10, 50, -1);
        check_band("short_run", 20 - MG, 31 + MG, 1);

        clear_frame();
        set_rows(0, H - 1, 5, 9);
        set_rows(0, H - 1, 50, 55);
        applyStimulus(10, 50, -1);
        check_band("out_of_window", 0, 0, 0);

        clear_frame();
        set_rows(40, 47, 20, 25);
        model_frame(10, 50, mu, md, mv);
        checkOutput("model_p4_down", md, 10'd47);
        applyStimulus(10, 50, -1);
        check_band("bottom", 40 - MG, 47, 1);

        clear_frame();
        set_rows(30, 37, 11, 12);
        set_rows(30, 37, 49, 49);
        set_rows(2, 12, 10, 12);
        set_rows(2, 12, 50, 50);
        applyStimulus(10, 50, -1);
        check_band("edges", 30 - MG, 37 + MG, 1);

        clear_frame();
        set_rows(0, 6, 20, 25);
        set_rows(10, 17, 20, 25);
        applyStimulus(10, 50, -1);
        check_band("min_height", (10 > MG) ? 10 - MG : 0, 17 + MG, 1);

        clear_frame();
        set_rows(12, 27, 20, 25);
        applyStimulus(10, 50, 20);
        check_band("reset_mid", 0, 0, 0);
        applyStimulus(10, 50, -1);
        check_band("after_reset", 12 - MG, 27 + MG, 1);

        applyStimulus(50, 10, -1);
        check_band("inverted_window", 0, 0, 0);

        for (int f = 0; f < 4; f++) begin
            clear_frame();
            for (int r = 0; r < H; r++)
                for (int k = $urandom_range(0, 4); k > 0; k--)
                    fg[r][$urandom_range(0, W - 1)] = 1;
            start = $urandom_range(0, 40);
            len = $urandom_range(3, 14);
            for (int r = start; r < start + len && r < H; r++)
                for (int k = $urandom_range(3, 8); k > 0; k--)
                    fg[r][$urandom_range(11, 49)] = 1;
            applyStimulus(10, 50, -1);
            check_band("random", int'(pend_up), int'(pend_down), pend_valid);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/char_horizontal_projection.md
# char_horizontal_projection

Finds the character band's top and bottom rows inside a located license plate. Sits directly upstream of the vertical projection stage. Per frame, it counts foreground pixels per row within a column window. It then picks the first run of populated rows that is tall enough, and publishes that run's first and last rows at the next frame boundary. Those rows become the vertical stage's `vertical_start`/`vertical_end`. The binary pixel stream passes through, delayed by 2 clocks.

## Interface
- `IMG_HDISP`, 10'd640, active pixels per line
- `IMG_VDISP`, 10'd480, active lines per frame
- `ROW_THRESH`, 10'd3, minimum in-window pixels for a row to count as populated
- `MIN_HEIGHT`, 10'd8, minimum run length (rows) accepted as the character band
- `MARGIN`, 10'd2, rows added above and below the band (used only with the macro)

Ports:
- `clk` input 1 pixel clock
- `rst_n` input 1 — one clock; reset is synchronous and active-low
- `per_frame_vsync` input 1 frame sync
- `per_frame_href` input 1 line valid
- `per_frame_clken` input 1 pixel enable
- `per_img_Bit` input 1 binary pixel (1 = foreground)
- `horizon_start` input 10 left column bound (exclusive)
- `horizon_end` input 10 right column bound (exclusive)
- `char_line_up` output 10 top row of band
- `char_line_down` output 10 bottom row of band
- `char_valid` output 1 band found in last completed frame
- `post_frame_vsync`, `post_frame_href`, `post_frame_clken`, `post_img_Bit` output 1 each: inputs delayed by 2 clocks

## Operation
- `x_cnt` (10b) counts the `per_frame_clken` pulses within a line and starts at 0. It is cleared at the href falling edge (`href_d1 & ~per_frame_href`).
- `y_cnt` (10b) increments at each href falling edge. It is cleared at the vsync falling edge.
- `row_sum` (10b) increments when all three hold:
  - `per_frame_clken & per_img_Bit`
  - `x_cnt > horizon_start`
  - `x_cnt < horizon_end`

  Max 640, so there is no overflow. `row_sum` is evaluated and cleared at the href falling edge.
- FSM states: IDLE, SEEK, BAND, LOCKED.
  - IDLE: entered at reset. Moves to SEEK on a vsync falling edge.
  - SEEK: if `row_sum >= ROW_THRESH` at row end, set `top <= y_cnt`, `run <= 1` and move to BAND.
  - BAND, populated row: `run++` and `bot <= y_cnt`.
  - BAND, empty row with `run >= MIN_HEIGHT`: move to LOCKED.
  - BAND, empty row with `run < MIN_HEIGHT`: move back to SEEK and discard the run.
  - LOCKED: holds until the frame ends.
- At the vsync rising edge (`vsync_d1 & ~vsync_d2`):
  - State BAND with `run >= MIN_HEIGHT`, or state LOCKED: publish `top`/`bot` and set `char_valid = 1`.
  - State SEEK, or BAND with a short run: outputs become 0/0 and `char_valid = 0`.
  - State IDLE (no frame start seen since reset): outputs hold.
  - FSM returns to IDLE on a vsync rising edge; the next vsync falling edge re-arms it.
- For a single-row band, `top == bot`.

## Timing
- Reset values:
  - `char_line_up`, `char_line_down`, `char_valid`: 0
  - all `post_*` outputs: 0
  - counters: 0
  - FSM: IDLE
- `post_*` = inputs sampled on 2 consecutive edges (2-clock latency).
- Publish timing:
  - Edge k samples `per_frame_vsync` = 1.
  - The rising-edge flag is high between k and k+1.
  - Outputs update at edge k+1.
- A row decision is made in the same cycle as the href falling edge. It uses `row_sum` including any pixel registered on the previous edge.
- If the href falling edge and the vsync rising edge coincide, the row is evaluated first and the publish uses the updated `top`/`bot`.
- Reset mid-frame: everything clears to IDLE. The partial frame is never published.
- `horizon_start >= horizon_end`: no pixel qualifies, so `char_valid = 0` at frame end.

## Configuration
- `CHAR_HPROJ_MARGIN_EN` defined:
  - Published `char_line_up = (top > MARGIN) ? top - MARGIN : 0`.
  - Published `char_line_down = min(bot + MARGIN, IMG_VDISP - 1)`.
- Undefined: raw `top`/`bot` are published, and `MARGIN` is unused.

## Test plan
- 64x48 frame, window (10,50).
  - Stimulus: rows 12–27 each have 6 fg pixels at cols 20–25.
  - Response: `char_line_up = 12`, `char_line_down = 27`, `char_valid = 1`, 2 clocks after vsync rises.
- Short run rejected.
  - Stimulus: rows 5–7 populated (3 rows), then rows 20–31 populated.
  - Response: up = 20, down = 31.
- Out-of-window pixels.
  - Stimulus: fg only at cols 5–9 and 50–55 on all rows.
  - Response: `char_valid = 0`, up = 0, down = 0.
- Band touches frame bottom.
  - Stimulus: rows 40–47 populated.
  - Response: up = 40, down = 47.
  - With `CHAR_HPROJ_MARGIN_EN` and `MARGIN = 2`: up = 38, down = 47 (clamped).
- Reset mid-frame.
  - Stimulus: assert `rst_n = 0` for 1 clock at row 20 of a frame with band rows 12–27.
  - Response: outputs 0 through that frame's vsync rise. The next full frame publishes 12/27.
- Pass-through check.
  - Stimulus: random `per_img_Bit` and sync pattern.
  - Response: every `post_*` equals its input delayed by exactly 2 clocks.
